// File: rtl/sha3_pkg.sv
// Shared SHA-3 digest-streaming types: digest modes, word counts, the Keccak
// state layout and the serialiser FSM states.
package sha3_pkg;

    typedef logic [4:0][4:0][63:0] sha3_state_t;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_e;

    localparam int WORDS_224 = 14;
    localparam int WORDS_256 = 16;
    localparam int WORDS_384 = 24;
    localparam int WORDS_512 = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sha3_fsm_e;

    // Index of the final 16-bit word; 32 words would not fit the 5-bit counter.
    function automatic logic [4:0] last_word_idx(input sha3_mode_e m);
        case (m)
            SHA3_224: return 5'(WORDS_224 - 1);
            SHA3_256: return 5'(WORDS_256 - 1);
            SHA3_384: return 5'(WORDS_384 - 1);
            default:  return 5'(WORDS_512 - 1);
        endcase
    endfunction

endpackage

// File: rtl/sha3_digest_axis.sv
// Serialises the leading lanes of a final Keccak state into an AXI-Stream of
// 16-bit digest words, little-endian byte order, length chosen by Mode.
module sha3_digest_axis
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [4:0][4:0][63:0]  Din,
    input  logic                   Din_valid,
    input  logic [1:0]             Mode,
    input  logic [1:0]             ID,
    output logic [DATA_WIDTH-1:0]  TDATA,
    output logic                   TVALID,
    input  logic                   TREADY,
    output logic                   TLAST,
    output logic [1:0]             TKEEP,
    output logic [1:0]             TID,
    output logic                   Busy,
    output logic                   Drop
);

    sha3_fsm_e         state_q, state_d;
    sha3_mode_e        mode_q, mode_d;
    logic [1:0]        tid_q, tid_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0][63:0]  hold_q;
    logic [7:0][63:0]  cap_lanes;
    logic [63:0]       sel_lane;
    logic              accept, drop_raw, last_beat, sending;
    sha3_state_t       din_w;
    logic              unused_lanes;

    assign din_w = Din;
    // Only lanes 0..7 can ever reach the output; the rest are deliberately ignored.
    assign unused_lanes = ^{din_w[4:2], din_w[1][4:3]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign cap_lanes[gi] = din_w[gi / 5][gi % 5];
        end
    endgenerate

    assign sending   = (state_q == ST_SEND);
    assign last_beat = sending && (cnt_q == last_word_idx(mode_q));

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        tid_d    = tid_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        drop_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Din_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SEND;
                    cnt_d   = '0;
                    mode_d  = sha3_mode_e'(Mode);
                    tid_d   = ID;
                end
            end
            ST_SEND: begin
                drop_raw = Din_valid;
                if (TREADY) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            mode_q  <= SHA3_224;
            tid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tid_q   <= tid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holding register carries no reset: it is only observed while sending.
    always_ff @(posedge ACLK) begin
        if (accept && !ARESET) begin
            hold_q <= cap_lanes;
        end
    end

    assign sel_lane = hold_q[cnt_q[4:2]];
    assign TDATA    = sending ? sel_lane[{cnt_q[1:0], 4'b0000} +: DATA_WIDTH] : '0;
    assign TVALID   = sending;
    assign TLAST    = last_beat;
    assign TID      = tid_q;
    assign TKEEP    = 2'b11;
    assign Busy     = sending;
    assign Drop     = drop_raw && !ARESET;

endmodule

// File: tb/tb_sha3_digest_axis.sv
// Directed bench for sha3_digest_axis: reset, SHA3-256 empty digest,
// backpressure, collision drops and mid-digest reset.
module tb_sha3_digest_axis;
    import sha3_pkg::*;

    logic                  ACLK = 1'b0;
    logic                  ARESET;
    logic [4:0][4:0][63:0] Din;
    logic                  Din_valid;
    logic [1:0]            Mode;
    logic [1:0]            ID;
    logic [15:0]           TDATA;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;
    logic [1:0]            TKEEP;
    logic [1:0]            TID;
    logic                  Busy;
    logic                  Drop;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_w [32];
    logic [1:0]  exp_tid;
    int          nb;

    // SHA3-256("") = a7ffc6f8bf1ed766 51c14756a061d662 f580ff4de43b49fa 82d80a4b80f8434a
    localparam logic [15:0] EMPTY_W [16] = '{
        16'hffa7, 16'hf8c6, 16'h1ebf, 16'h66d7,
        16'hc151, 16'h5647, 16'h61a0, 16'h62d6,
        16'h80f5, 16'h4dff, 16'h3be4, 16'hfa49,
        16'hd882, 16'h4b0a, 16'hf880, 16'h4a43
    };

    sha3_digest_axis #(.DATA_WIDTH(16)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .Din       (Din),
        .Din_valid (Din_valid),
        .Mode      (Mode),
        .ID        (ID),
        .TDATA     (TDATA),
        .TVALID    (TVALID),
        .TREADY    (TREADY),
        .TLAST     (TLAST),
        .TKEEP     (TKEEP),
        .TID       (TID),
        .Busy      (Busy),
        .Drop      (Drop)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Loads Din (pattern word k = {pat, k} or the empty-message digest) and pulses Din_valid.
    task automatic start(input logic [1:0] m, input logic [1:0] id,
                         input logic [7:0] pat, input bit empty);
        @(negedge ACLK);
        check_eq("idle_tvalid", TVALID, 1'b0);
        check_eq("idle_busy", Busy, 1'b0);
        if (empty) begin
            Din = {25{64'h0123456789abcdef}};
            Din[0][0] = 64'h66d71ebff8c6ffa7;
            Din[0][1] = 64'h62d661a05647c151;
            Din[0][2] = 64'hfa493be44dff80f5;
            Din[0][3] = 64'h4a43f8804b0ad882;
            for (int k = 0; k < 32; k++) exp_w[k] = (k < 16) ? EMPTY_W[k] : 16'h0000;
        end else begin
            for (int l = 0; l < 25; l++)
                for (int s = 0; s < 4; s++)
                    Din[l / 5][l % 5][16 * s +: 16] = (l < 8) ? {pat, 8'(4 * l + s)} : 16'hDEAD;
            for (int k = 0; k < 32; k++) exp_w[k] = {pat, 8'(k)};
        end
        Mode      = m;
        ID        = id;
        exp_tid   = id;
        TREADY    = 1'b1;
        Din_valid = 1'b1;
        #1;
        check_eq("accept_drop", Drop, 1'b0);
    endtask

    task automatic recv(input int exp_n, input bit stall, input int coll_beat,
                        input bit coll_last, input int abort_beat, output int nbeats);
        logic [15:0] prev_d;
        logic        prev_l;
        bit          prev_stall, done, coll_done, rdy, dv;
        nbeats     = 0;
        prev_stall = 1'b0;
        done       = 1'b0;
        coll_done  = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge ACLK);
            Din_valid = 1'b0;
            Mode      = 2'($urandom);
            ID        = 2'($urandom);
            if (cyc == 0) check_eq("latency_tvalid", TVALID, 1'b1);
            if (abort_beat >= 0 && nbeats == abort_beat) begin
                ARESET = 1'b1;
                #1;
                done = 1'b1;
            end else begin
                if (prev_stall) begin
                    check_eq("stall_tdata", TDATA, prev_d);
                    check_eq("stall_tlast", TLAST, prev_l);
                end
                rdy = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
                dv  = TVALID && ((nbeats == coll_beat && !coll_done) || (coll_last && TLAST && rdy));
                if (nbeats == coll_beat) coll_done = 1'b1;
                if (dv) Din = {25{64'hEEEEEEEEEEEEEEEE}};
                TREADY    = rdy;
                Din_valid = dv;
                #1;
                check_eq("drop", Drop, dv);
                check_eq("tvalid", TVALID, 1'b1);
                prev_stall = TVALID && !rdy;
                prev_d     = TDATA;
                prev_l     = TLAST;
                if (TVALID && rdy) begin
                    check_eq("tdata", TDATA, exp_w[nbeats % 32]);
                    check_eq("tid", TID, exp_tid);
                    check_eq("tlast", TLAST, nbeats == exp_n - 1);
                    if (TLAST) done = 1'b1;
                    nbeats++;
                end
            end
        end
        if (!done) check_eq("timeout", 1'b0, 1'b1);
        $display("digest done: words=%0d expected=%0d tid=%0d", nbeats, exp_n, exp_tid);
    endtask

    task automatic idle_check();
        @(negedge ACLK);
        Din_valid = 1'b0;
        #1;
        check_eq("post_tvalid", TVALID, 1'b0);
        check_eq("post_busy", Busy, 1'b0);
        check_eq("post_tlast", TLAST, 1'b0);
    endtask

    initial begin
        ARESET    = 1'b1;
        Din_valid = 1'b0;
        TREADY    = 1'b1;
        Mode      = 2'd0;
        ID        = 2'd0;
        Din       = '0;
        exp_tid   = 2'd0;
        @(posedge ACLK);
        // Reset held 3 cycles; a Din_valid during reset must be ignored silently.
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            Din_valid = (i == 1);
            Mode      = 2'd3;
            ID        = 2'd3;
            #1;
            check_eq("rst_tvalid", TVALID, 1'b0);
            check_eq("rst_tlast", TLAST, 1'b0);
            check_eq("rst_busy", Busy, 1'b0);
            if (i == 1) check_eq("rst_drop", Drop, 1'b0);
        end
        @(negedge ACLK);
        ARESET    = 1'b0;
        Din_valid = 1'b0;
        #1;
        check_eq("rst_tdata", TDATA, 16'h0000);
        check_eq("rst_tid", TID, 2'd0);
        check_eq("tkeep", TKEEP, 2'b11);
        idle_check();

        start(2'd1, 2'd2, 8'h00, 1'b1);
        recv(16, 1'b0, -1, 1'b0, -1, nb);
        check_eq("sha3_256_beats", nb, 16);
        idle_check();

        start(2'd0, 2'd3, 8'hB4, 1'b0);
        recv(14, 1'b1, -1, 1'b0, -1, nb);
        check_eq("bp_beats", nb, 14);
        idle_check();

        start(2'd3, 2'd1, 8'h91, 1'b0);
        recv(32, 1'b0, 5, 1'b1, -1, nb);
        check_eq("coll_beats", nb, 32);
        start(2'd0, 2'd0, 8'h4E, 1'b0);
        recv(14, 1'b0, -1, 1'b0, -1, nb);
        check_eq("after_coll_beats", nb, 14);
        idle_check();

        start(2'd2, 2'd2, 8'h3C, 1'b0);
        recv(24, 1'b0, -1, 1'b0, 10, nb);
        check_eq("abort_beats", nb, 10);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check_eq("abort_tvalid", TVALID, 1'b0);
        check_eq("abort_tlast", TLAST, 1'b0);
        check_eq("abort_busy", Busy, 1'b0);
        check_eq("abort_tid", TID, 2'd0);
        start(2'd1, 2'd1, 8'h77, 1'b0);
        recv(16, 1'b0, -1, 1'b0, -1, nb);
        check_eq("post_abort_beats", nb, 16);
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
